// File: rtl/dmem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              p0_mem_read;
    logic              p0_mem_write;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [1:0]        p0_store_type;
    logic [2:0]        p0_load_type;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_mem_read;
    logic              p1_mem_write;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [1:0]        p1_store_type;
    logic [2:0]        p1_load_type;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic              stall_p0;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_store_type;
    logic [2:0]        mem_load_type;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_mem_read, p0_mem_write, p0_addr, p0_wdata, p0_store_type, p0_load_type,
        input  p1_mem_read, p1_mem_write, p1_addr, p1_wdata, p1_store_type, p1_load_type,
        output p0_done, p0_rdata, p1_done, p1_rdata, stall_p0,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_store_type, mem_load_type,
        input  mem_rdata
    );

    modport master (
        output p0_mem_read, p0_mem_write, p0_addr, p0_wdata, p0_store_type, p0_load_type,
        output p1_mem_read, p1_mem_write, p1_addr, p1_wdata, p1_store_type, p1_load_type,
        input  p0_done, p0_rdata, p1_done, p1_rdata, stall_p0,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_store_type, mem_load_type,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single data-memory port: port 0 is the MEM stage, port 1 is
// debug/DMA. One access at a time: latch winner, strobe once, wait out read latency,
// pulse done with registered read data.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_LAT  = 1,
    parameter bit          FIXED_PRI = 1'b0
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    // Last WAIT cycle count; unused when READ_LAT is 0 (ISSUE goes straight to RESP).
    localparam logic [2:0] CntLast = (READ_LAT == 0) ? 3'd0 : 3'(READ_LAT - 1);

    state_e            state_q, state_d;
    logic              p0_req, p1_req;
    logic              load_en, load_sel;
    logic              grant_q, last_grant_q, is_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        store_type_q;
    logic [2:0]        load_type_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done0, done1;

    assign p0_req = bus.p0_mem_read | bus.p0_mem_write;
    assign p1_req = bus.p1_mem_read | bus.p1_mem_write;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state and grant selection
    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        load_sel = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (p0_req || p1_req) begin
                    load_en = 1'b1;
                    state_d = StIssue;
                    if (p0_req && p1_req) load_sel = FIXED_PRI ? 1'b0 : ~last_grant_q;
                    else                  load_sel = p1_req;
                end
            end
            StIssue: begin
                if (is_write_q || READ_LAT == 0) state_d = StResp;
                else                             state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CntLast) state_d = StResp;
            end
            StResp: begin
                // The finishing port still holds its request this cycle, so only the
                // other port can be picked up without an IDLE bubble.
                if (grant_q ? p0_req : p1_req) begin
                    load_en  = 1'b1;
                    load_sel = ~grant_q;
                    state_d  = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Latch the winning request's fields at grant; ignored afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= 1'b0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            store_type_q <= '0;
            load_type_q  <= '0;
        end else if (load_en) begin
            grant_q      <= load_sel;
            // Write wins when both read and write are set.
            is_write_q   <= load_sel ? bus.p1_mem_write  : bus.p0_mem_write;
            addr_q       <= load_sel ? bus.p1_addr       : bus.p0_addr;
            wdata_q      <= load_sel ? bus.p1_wdata      : bus.p0_wdata;
            store_type_q <= load_sel ? bus.p1_store_type : bus.p0_store_type;
            load_type_q  <= load_sel ? bus.p1_load_type  : bus.p0_load_type;
        end
    end

    // Pick the cycle in which mem_rdata is valid for the outstanding load
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == StIssue) begin
            if (is_write_q)         rdata_d = '0;
            else if (READ_LAT == 0) rdata_d = bus.mem_rdata;
        end else if (state_q == StWait && cnt_q == CntLast) begin
            rdata_d = bus.mem_rdata;
        end
    end

    // Latency counter, captured read data and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            rdata_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            if (state_q == StIssue)     cnt_q <= '0;
            else if (state_q == StWait) cnt_q <= cnt_q + 3'd1;
            rdata_q <= rdata_d;
            if (state_q == StResp) last_grant_q <= grant_q;
        end
    end

    // Memory strobes, completion pulses and pipeline stall
    always_comb begin
        done0              = (state_q == StResp) && !grant_q;
        done1              = (state_q == StResp) && grant_q;
        bus.p0_done        = done0;
        bus.p1_done        = done1;
        bus.p0_rdata       = done0 ? rdata_q : '0;
        bus.p1_rdata       = done1 ? rdata_q : '0;
        // Held low during reset so every output reads 0 while rst is asserted.
        bus.stall_p0       = p0_req && !done0 && !rst;
        bus.mem_read       = (state_q == StIssue) && !is_write_q;
        bus.mem_write      = (state_q == StIssue) && is_write_q;
        bus.mem_addr       = addr_q;
        bus.mem_wdata      = wdata_q;
        bus.mem_store_type = store_type_q;
        bus.mem_load_type  = load_type_q;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: four instances cover round-robin and fixed
// priority, and read latencies of 0, 1 and 3.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ic ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) id ();

    dmem_port_arbiter #(.READ_LAT(1), .FIXED_PRI(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ia));
    dmem_port_arbiter #(.READ_LAT(1), .FIXED_PRI(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ib));
    dmem_port_arbiter #(.READ_LAT(3), .FIXED_PRI(1'b0)) u_c (.clk(clk), .rst(rst), .bus(ic));
    dmem_port_arbiter #(.READ_LAT(0), .FIXED_PRI(1'b0)) u_d (.clk(clk), .rst(rst), .bus(id));

    // Memory A: writable, one-cycle synchronous read, garbage when not reading
    logic [31:0] mem_a [64];
    logic [31:0] rd_a;
    always @(posedge clk) begin
        if (rst) begin
            mem_a[4] <= 32'hDEAD_BEEF;
            mem_a[5] <= 32'h1111_2222;
            mem_a[8] <= 32'h0000_0000;
        end else if (ia.mem_write) begin
            mem_a[ia.mem_addr[7:2]] <= ia.mem_wdata;
        end
        rd_a <= ia.mem_read ? mem_a[ia.mem_addr[7:2]] : 32'h0BAD_0BAD;
    end
    assign ia.mem_rdata = rd_a;

    // Memory B: data = addr ^ 5A5A0000, one-cycle latency
    logic [31:0] rd_b;
    always @(posedge clk) rd_b <= ib.mem_read ? (ib.mem_addr ^ 32'h5A5A_0000) : 32'h0BAD_0BAD;
    assign ib.mem_rdata = rd_b;

    // Memory C: data = addr ^ 3C3C0000, three-cycle latency
    logic [31:0] c0, c1, c2;
    always @(posedge clk) begin
        c0 <= ic.mem_read ? (ic.mem_addr ^ 32'h3C3C_0000) : 32'h0BAD_0BAD;
        c1 <= c0;
        c2 <= c1;
    end
    assign ic.mem_rdata = c2;

    // Memory D: combinational, only valid while mem_read is high
    assign id.mem_rdata = id.mem_read ? (id.mem_addr ^ 32'h7777_0000) : 32'h0BAD_0BAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {ia.p0_mem_read, ia.p0_mem_write, ia.p1_mem_read, ia.p1_mem_write} = '0;
        {ia.p0_addr, ia.p0_wdata, ia.p1_addr, ia.p1_wdata} = '0;
        {ia.p0_store_type, ia.p0_load_type, ia.p1_store_type, ia.p1_load_type} = '0;
        {ib.p0_mem_read, ib.p0_mem_write, ib.p1_mem_read, ib.p1_mem_write} = '0;
        {ib.p0_addr, ib.p0_wdata, ib.p1_addr, ib.p1_wdata} = '0;
        {ib.p0_store_type, ib.p0_load_type, ib.p1_store_type, ib.p1_load_type} = '0;
        {ic.p0_mem_read, ic.p0_mem_write, ic.p1_mem_read, ic.p1_mem_write} = '0;
        {ic.p0_addr, ic.p0_wdata, ic.p1_addr, ic.p1_wdata} = '0;
        {ic.p0_store_type, ic.p0_load_type, ic.p1_store_type, ic.p1_load_type} = '0;
        {id.p0_mem_read, id.p0_mem_write, id.p1_mem_read, id.p1_mem_write} = '0;
        {id.p0_addr, id.p0_wdata, id.p1_addr, id.p1_wdata} = '0;
        {id.p0_store_type, id.p0_load_type, id.p1_store_type, id.p1_load_type} = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // A pending port-0 request must not show as a stall while reset is held.
        ia.p0_mem_read = 1'b1;
        ia.p0_addr     = 32'h10;
        #1;
        checks++; if (ia.stall_p0 !== 1'b0)
            begin errors++; $display("FAIL rst_stall got %0h want 0", ia.stall_p0); end
        checks++; if ({ia.mem_read, ia.mem_write, ia.p0_done, ia.p1_done} !== 4'b0)
            begin errors++; $display("FAIL rst_strobes got %0h want 0",
                {ia.mem_read, ia.mem_write, ia.p0_done, ia.p1_done}); end
        checks++; if ({ia.mem_addr, ia.mem_wdata, ia.p0_rdata, ia.p1_rdata} !== 128'b0)
            begin errors++; $display("FAIL rst_data got %0h want 0",
                {ia.mem_addr, ia.mem_wdata, ia.p0_rdata, ia.p1_rdata}); end
        checks++; if ({ia.mem_store_type, ia.mem_load_type} !== 5'b0)
            begin errors++; $display("FAIL rst_types got %0h want 0",
                {ia.mem_store_type, ia.mem_load_type}); end
        ia.p0_mem_read = 1'b0;
        ia.p0_addr     = '0;
    endtask

    task automatic test_single_load();
        ia.p0_mem_read  = 1'b1;
        ia.p0_addr      = 32'h10;
        ia.p0_load_type = 3'b010;
        #1;
        checks++; if (ia.stall_p0 !== 1'b1 || ia.mem_read !== 1'b0)
            begin errors++; $display("FAIL t1_cyc_t got stall=%0h rd=%0h want 1 0",
                ia.stall_p0, ia.mem_read); end
        tick();
        checks++; if (ia.mem_read !== 1'b1 || ia.mem_addr !== 32'h10)
            begin errors++; $display("FAIL t1_issue got rd=%0h addr=%0h want 1 10",
                ia.mem_read, ia.mem_addr); end
        checks++; if (ia.mem_load_type !== 3'b010 || ia.stall_p0 !== 1'b1)
            begin errors++; $display("FAIL t1_issue_lt got lt=%0h stall=%0h want 2 1",
                ia.mem_load_type, ia.stall_p0); end
        tick();
        checks++; if (ia.mem_read !== 1'b0 || ia.p0_done !== 1'b0 || ia.stall_p0 !== 1'b1)
            begin errors++; $display("FAIL t1_wait got rd=%0h done=%0h stall=%0h want 0 0 1",
                ia.mem_read, ia.p0_done, ia.stall_p0); end
        tick();
        checks++; if (ia.p0_done !== 1'b1 || ia.p0_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL t1_done got done=%0h data=%0h want 1 deadbeef",
                ia.p0_done, ia.p0_rdata); end
        checks++; if (ia.stall_p0 !== 1'b0 || ia.p1_done !== 1'b0)
            begin errors++; $display("FAIL t1_resp got stall=%0h p1done=%0h want 0 0",
                ia.stall_p0, ia.p1_done); end
        ia.p0_mem_read = 1'b0;
        tick();
        checks++; if (ia.p0_done !== 1'b0 || ia.p0_rdata !== 32'h0)
            begin errors++; $display("FAIL t1_after got done=%0h data=%0h want 0 0",
                ia.p0_done, ia.p0_rdata); end
    endtask

    task automatic test_round_robin();
        ia.p0_mem_read = 1'b1; ia.p0_addr = 32'h10;
        ia.p1_mem_read = 1'b1; ia.p1_addr = 32'h14;
        tick();
        checks++; if (ia.mem_addr !== 32'h10)
            begin errors++; $display("FAIL t2_first_p0 got addr=%0h want 10", ia.mem_addr); end
        tick();
        tick();
        checks++; if (ia.p0_done !== 1'b1 || ia.p1_done !== 1'b0 || ia.p0_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL t2_p0_done got %0h %0h %0h want 1 0 deadbeef",
                ia.p0_done, ia.p1_done, ia.p0_rdata); end
        ia.p0_mem_read = 1'b0;
        tick();
        checks++; if (ia.mem_read !== 1'b1 || ia.mem_addr !== 32'h14)
            begin errors++; $display("FAIL t2_p1_direct got rd=%0h addr=%0h want 1 14",
                ia.mem_read, ia.mem_addr); end
        tick();
        tick();
        checks++; if (ia.p1_done !== 1'b1 || ia.p1_rdata !== 32'h1111_2222 || ia.p0_rdata !== 0)
            begin errors++; $display("FAIL t2_p1_done got %0h %0h %0h want 1 11112222 0",
                ia.p1_done, ia.p1_rdata, ia.p0_rdata); end
        ia.p1_mem_read = 1'b0;
        tick();
        // Tie with p1 last granted: p0 wins.
        ia.p0_mem_read = 1'b1;
        ia.p1_mem_read = 1'b1;
        tick();
        checks++; if (ia.mem_addr !== 32'h10)
            begin errors++; $display("FAIL t2_tie_p0 got addr=%0h want 10", ia.mem_addr); end
        tick();
        tick();
        ia.p0_mem_read = 1'b0;
        ia.p1_mem_read = 1'b0;
        tick();
        // Tie with p0 last granted: p1 wins.
        ia.p0_mem_read = 1'b1;
        ia.p1_mem_read = 1'b1;
        tick();
        checks++; if (ia.mem_addr !== 32'h14)
            begin errors++; $display("FAIL t2_tie_p1 got addr=%0h want 14", ia.mem_addr); end
        tick();
        tick();
        ia.p0_mem_read = 1'b0;
        ia.p1_mem_read = 1'b0;
        tick();
    endtask

    task automatic test_store_priority();
        ia.p1_mem_write   = 1'b1;
        ia.p1_mem_read    = 1'b1;
        ia.p1_addr        = 32'h20;
        ia.p1_wdata       = 32'hA5A5_A5A5;
        ia.p1_store_type  = 2'b10;
        tick();
        checks++; if (ia.mem_write !== 1'b1 || ia.mem_read !== 1'b0)
            begin errors++; $display("FAIL t4_strobe got wr=%0h rd=%0h want 1 0",
                ia.mem_write, ia.mem_read); end
        checks++; if (ia.mem_addr !== 32'h20 || ia.mem_wdata !== 32'hA5A5_A5A5)
            begin errors++; $display("FAIL t4_bus got addr=%0h wd=%0h want 20 a5a5a5a5",
                ia.mem_addr, ia.mem_wdata); end
        checks++; if (ia.mem_store_type !== 2'b10)
            begin errors++; $display("FAIL t4_st got %0h want 2", ia.mem_store_type); end
        tick();
        checks++; if (ia.p1_done !== 1'b1 || ia.p1_rdata !== 32'h0 || ia.mem_write !== 1'b0)
            begin errors++; $display("FAIL t4_done got done=%0h rd=%0h wr=%0h want 1 0 0",
                ia.p1_done, ia.p1_rdata, ia.mem_write); end
        ia.p1_mem_write = 1'b0;
        ia.p1_mem_read  = 1'b0;
        tick();
        checks++; if (ia.p1_done !== 1'b0 || ia.mem_write !== 1'b0)
            begin errors++; $display("FAIL t4_idle got done=%0h wr=%0h want 0 0",
                ia.p1_done, ia.mem_write); end
        ia.p0_mem_read = 1'b1;
        ia.p0_addr     = 32'h20;
        tick();
        // Address change after grant must not reach the memory.
        ia.p0_addr = 32'h10;
        tick();
        checks++; if (ia.mem_addr !== 32'h20)
            begin errors++; $display("FAIL t4_latched got addr=%0h want 20", ia.mem_addr); end
        tick();
        checks++; if (ia.p0_done !== 1'b1 || ia.p0_rdata !== 32'hA5A5_A5A5)
            begin errors++; $display("FAIL t4_readback got done=%0h data=%0h want 1 a5a5a5a5",
                ia.p0_done, ia.p0_rdata); end
        ia.p0_mem_read = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        ib.p0_mem_read = 1'b1;
        ib.p0_addr     = 32'h100;
        tick();
        checks++; if (ib.mem_addr !== 32'h100)
            begin errors++; $display("FAIL t3_first got addr=%0h want 100", ib.mem_addr); end
        tick();
        tick();
        checks++; if (ib.p0_done !== 1'b1 || ib.p0_rdata !== 32'h5A5A_0100)
            begin errors++; $display("FAIL t3_p0a got done=%0h data=%0h want 1 5a5a0100",
                ib.p0_done, ib.p0_rdata); end
        ib.p0_mem_read = 1'b0;
        tick();
        // p0 was last granted; fixed priority still gives p0 the tie.
        ib.p0_mem_read = 1'b1; ib.p0_addr = 32'h104;
        ib.p1_mem_read = 1'b1; ib.p1_addr = 32'h40;
        tick();
        checks++; if (ib.mem_addr !== 32'h104 || ib.mem_read !== 1'b1)
            begin errors++; $display("FAIL t3_p0_wins got addr=%0h rd=%0h want 104 1",
                ib.mem_addr, ib.mem_read); end
        tick();
        checks++; if (ib.p1_done !== 1'b0)
            begin errors++; $display("FAIL t3_p1_waits got %0h want 0", ib.p1_done); end
        tick();
        checks++; if (ib.p0_done !== 1'b1 || ib.p0_rdata !== 32'h5A5A_0104 || ib.p1_done !== 0)
            begin errors++; $display("FAIL t3_p0b got %0h %0h %0h want 1 5a5a0104 0",
                ib.p0_done, ib.p0_rdata, ib.p1_done); end
        ib.p0_mem_read = 1'b0;
        tick();
        checks++; if (ib.mem_read !== 1'b1 || ib.mem_addr !== 32'h40)
            begin errors++; $display("FAIL t3_p1_grant got rd=%0h addr=%0h want 1 40",
                ib.mem_read, ib.mem_addr); end
        tick();
        tick();
        checks++; if (ib.p1_done !== 1'b1 || ib.p1_rdata !== 32'h5A5A_0040)
            begin errors++; $display("FAIL t3_p1_done got done=%0h data=%0h want 1 5a5a0040",
                ib.p1_done, ib.p1_rdata); end
        ib.p1_mem_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        ic.p0_mem_read = 1'b1;
        ic.p0_addr     = 32'h44;
        tick();
        checks++; if (ic.mem_read !== 1'b1)
            begin errors++; $display("FAIL t5_issue got %0h want 1", ic.mem_read); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({ic.mem_read, ic.mem_write, ic.p0_done, ic.p1_done, ic.stall_p0} !== 5'b0)
            begin errors++; $display("FAIL t5_async_ctl got %0h want 0",
                {ic.mem_read, ic.mem_write, ic.p0_done, ic.p1_done, ic.stall_p0}); end
        checks++; if ({ic.mem_addr, ic.mem_wdata, ic.p0_rdata, ic.p1_rdata} !== 128'b0)
            begin errors++; $display("FAIL t5_async_data got %0h want 0",
                {ic.mem_addr, ic.mem_wdata, ic.p0_rdata, ic.p1_rdata}); end
        ic.p0_mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ic.p0_done !== 1'b0)
                begin errors++; $display("FAIL t5_no_done got %0h want 0", ic.p0_done); end
        end
        rst = 1'b0;
        ic.p0_mem_read = 1'b1;
        ic.p0_addr     = 32'h48;
        tick();
        checks++; if (ic.mem_read !== 1'b1 || ic.mem_addr !== 32'h48)
            begin errors++; $display("FAIL t5_reissue got rd=%0h addr=%0h want 1 48",
                ic.mem_read, ic.mem_addr); end
        tick();
        tick();
        tick();
        checks++; if (ic.p0_done !== 1'b0)
            begin errors++; $display("FAIL t5_early got %0h want 0", ic.p0_done); end
        tick();
        checks++; if (ic.p0_done !== 1'b1 || ic.p0_rdata !== 32'h3C3C_0048)
            begin errors++; $display("FAIL t5_done got done=%0h data=%0h want 1 3c3c0048",
                ic.p0_done, ic.p0_rdata); end
        ic.p0_mem_read = 1'b0;
        tick();
    endtask

    task automatic test_lat0();
        id.p0_mem_read = 1'b1;
        id.p0_addr     = 32'h50;
        tick();
        checks++; if (id.mem_read !== 1'b1 || id.p0_done !== 1'b0)
            begin errors++; $display("FAIL t6_issue got rd=%0h done=%0h want 1 0",
                id.mem_read, id.p0_done); end
        tick();
        checks++; if (id.p0_done !== 1'b1 || id.p0_rdata !== 32'h7777_0050)
            begin errors++; $display("FAIL t6_done got done=%0h data=%0h want 1 77770050",
                id.p0_done, id.p0_rdata); end
        id.p0_mem_read = 1'b0;
        tick();
        checks++; if (id.p0_done !== 1'b0 || id.mem_read !== 1'b0)
            begin errors++; $display("FAIL t6_idle got done=%0h rd=%0h want 0 0",
                id.p0_done, id.mem_read); end
    endtask

    initial begin
        clear_inputs();
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single_load();
        apply_reset();
        test_round_robin();
        test_store_priority();
        test_fixed_priority();
        test_reset_mid_access();
        test_lat0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
